// File: rtl/mult18_seq.sv
// Sequential unsigned shift-add multiplier on the calc_start/done 4-phase handshake.
// Consumes BITS_PER_STEP multiplier bits per cycle and returns the exact 2*WIDTH-bit product.
module mult18_seq #(
    parameter int WIDTH         = 18,
    parameter int BITS_PER_STEP = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 calc_start,
    input  logic [WIDTH-1:0]     dataa,
    input  logic [WIDTH-1:0]     datab,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy
);
    // state | meaning
    // IDLE  | waiting for calc_start; result holds the last product
    // CALC  | one multiplier slice accumulated per edge; calc_start low aborts
    // DONE  | product valid, waiting for calc_start to drop
    localparam int N  = WIDTH / BITS_PER_STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int SW = $clog2(2 * WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] acc, pp, acc_sum;
    logic [CW-1:0]      cnt;
    logic [SW-1:0]      shamt;
    logic               last, done_nxt, busy_nxt;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (calc_start) state_nxt = CALC;
            CALC:    if (!calc_start) state_nxt = IDLE;
                     else if (last)   state_nxt = DONE;
            DONE:    if (!calc_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done/busy are registered copies of the decoded next state
    always_comb begin
        done_nxt = (state_nxt == DONE);
        busy_nxt = (state_nxt == CALC);
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_STEP; i++) begin
            if (b_reg[i]) pp = pp + ({{WIDTH{1'b0}}, a_reg} << i);
        end
        shamt   = SW'(cnt) * SW'(BITS_PER_STEP);
        acc_sum = acc + (pp << shamt);
        last    = (cnt == CW'(N - 1));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= done_nxt;
            busy <= busy_nxt;
            case (state)
                IDLE: begin
                    if (calc_start) begin
                        a_reg <= dataa;
                        b_reg <= datab;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (calc_start) begin
                        acc   <= acc_sum;
                        b_reg <= b_reg >> BITS_PER_STEP;
                        cnt   <= cnt + CW'(1);
                        if (last) result <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult18_seq.sv
// Self-checking bench for mult18_seq: directed handshake cases plus random products
// against plain-arithmetic expectations, for 1 and 2 bits per step.
module tb_mult18_seq;
    logic        CLK;
    logic        RST;
    logic        start [2];
    logic [17:0] da [2];
    logic [17:0] db [2];
    logic [35:0] res [2];
    logic        done [2];
    logic        busy [2];

    int errors = 0;
    int checks = 0;

    mult18_seq #(.WIDTH(18), .BITS_PER_STEP(1)) dut1 (
        .CLK(CLK), .RST(RST), .calc_start(start[0]), .dataa(da[0]), .datab(db[0]),
        .result(res[0]), .done(done[0]), .busy(busy[0])
    );

    mult18_seq #(.WIDTH(18), .BITS_PER_STEP(2)) dut2 (
        .CLK(CLK), .RST(RST), .calc_start(start[1]), .dataa(da[1]), .datab(db[1]),
        .result(res[1]), .done(done[1]), .busy(busy[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Full 4-phase transaction; when scramble is set the operands change right after capture.
    task automatic txn(input int u, input logic [17:0] a, input logic [17:0] b,
                       input logic [35:0] exp, input bit scramble, input string tag);
        int lat;
        int k;
        lat = (u == 0) ? 18 : 9;
        da[u] = a;
        db[u] = b;
        start[u] = 1'b1;
        tick();
        chk({tag, "_busy"}, 64'(busy[u]), 64'd1);
        if (scramble) begin
            da[u] = 18'($urandom);
            db[u] = 18'($urandom);
        end
        k = 1;
        while (!done[u] && k < 40) begin
            tick();
            if (!done[u]) k++;
        end
        chk({tag, "_latency"}, 64'(k), 64'(lat));
        chk({tag, "_result"}, 64'(res[u]), 64'(exp));
        repeat (2) tick();
        chk({tag, "_hold"}, {27'd0, done[u], res[u]}, {27'd0, 1'b1, exp});
        start[u] = 1'b0;
        tick();
        chk({tag, "_done_fall"}, 64'(done[u]), 64'd0);
    endtask

    initial begin
        logic [17:0] a;
        logic [17:0] b;
        logic [35:0] prev;
        logic        seen;

        RST = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0;
            da[u] = '0;
            db[u] = '0;
        end
        repeat (2) tick();
        RST = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_u0", {27'd0, done[0], busy[0], res[0]}, 64'd0);
            chk("idle_u1", {27'd0, done[1], busy[1], res[1]}, 64'd0);
        end

        txn(0, 18'h08240, 18'h07DC0, 36'h03FFAF000, 1'b0, "directed");
        txn(0, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001, 1'b0, "max_max");
        txn(0, 18'h10000, 18'h10000, 36'h100000000, 1'b0, "pow2");
        txn(1, 18'h3FFFF, 18'h3FFFF, 36'hFFFF80001, 1'b0, "max_max_b2");
        txn(1, 18'h10000, 18'h10000, 36'h100000000, 1'b0, "pow2_b2");
        txn(0, 18'h2F0F1, 18'h1A5A5, 36'h2F0F1 * 36'h1A5A5, 1'b0, "mixed");
        txn(0, 18'h00000, 18'h3FFFF, 36'h0, 1'b0, "zero");

        // abort after capture: result must keep the previous product
        txn(0, 18'h01234, 18'h05678, 36'h01234 * 36'h05678, 1'b0, "pre_abort");
        prev = 36'h01234 * 36'h05678;
        da[0] = 18'h3ABCD;
        db[0] = 18'h2DCBA;
        start[0] = 1'b1;
        repeat (5) tick();
        start[0] = 1'b0;
        tick();
        chk("abort_state", {27'd0, done[0], busy[0], res[0]}, {28'd0, prev});
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            seen = seen | done[0];
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        chk("abort_result", 64'(res[0]), 64'(prev));
        txn(0, 18'd3, 18'd5, 36'd15, 1'b0, "after_abort");

        // operand change after capture has no effect
        da[0] = 18'd7;
        db[0] = 18'd6;
        start[0] = 1'b1;
        tick();
        da[0] = 18'd9;
        db[0] = 18'd2;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = done[0];
        end
        chk("opchg_done", 64'(seen), 64'd1);
        chk("opchg_result", 64'(res[0]), 64'd42);
        start[0] = 1'b0;
        tick();

        // reset pulsed mid-calculation
        txn(1, 18'h00101, 18'h00202, 36'h00101 * 36'h00202, 1'b0, "pre_rst");
        da[0] = 18'h12345;
        db[0] = 18'h23456;
        start[0] = 1'b1;
        da[1] = 18'h3FFFF;
        db[1] = 18'h00003;
        start[1] = 1'b1;
        repeat (5) tick();
        RST = 1'b1;
        start[0] = 1'b0;
        start[1] = 1'b0;
        tick();
        chk("rst_u0", {27'd0, done[0], busy[0], res[0]}, 64'd0);
        chk("rst_u1", {27'd0, done[1], busy[1], res[1]}, 64'd0);
        RST = 1'b0;
        tick();
        txn(0, 18'h2AAAA, 18'h15555, 36'h2AAAA * 36'h15555, 1'b0, "post_rst");
        txn(1, 18'h2AAAA, 18'h15555, 36'h2AAAA * 36'h15555, 1'b0, "post_rst_b2");

        // random back-to-back products, both step widths
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 1000; n++) begin
                case ($urandom_range(0, 7))
                    0:       a = 18'h3FFFF;
                    1:       a = 18'h0;
                    default: a = 18'($urandom);
                endcase
                case ($urandom_range(0, 7))
                    0:       b = 18'h3FFFF;
                    1:       b = 18'h1;
                    default: b = 18'($urandom);
                endcase
                txn(u, a, b, 36'(a) * 36'(b), 1'b1, (u == 0) ? "rand_b1" : "rand_b2");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
